timer_core_param: RTL
=====================

Name: timer_core_param

Overview:
- Parametrised successor to the fixed 60 s stopwatch/countdown core.
- Generalises seconds range (SEC_DIGITS BCD digits) and tick rate.
- Adds on-chip key debounce, lap-hold display, optional wrap or saturate on overflow, and a timed alarm pulse.
- Sits between the raw board keys and the seven-segment encoder; outputs BCD only, and segment encoding stays downstream.

Parameters:
- CLK_HZ, 50_000_000: input clock frequency.
- SEC_DIGITS, 2: number of BCD seconds digits (1..4).
- DEBOUNCE_CYC, 500_000: cycles a key level must be stable before it is accepted.
- ALARM_TICKS, 30: alarm duration in 0.1 s ticks.
- WRAP_UP, 0: count-up at maximum. 1 = wrap to 0; 0 = stop and go to DONE.

Ports:
- clk_50M  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable. 0 freezes the tick divider and ignores key events; debouncers keep running.
- key_up_n  in  1  start count-up from 0. Active-low raw key.
- key_down_n  in  1  start countdown from preset. Active-low raw key.
- key_pause_n  in  1  pause/resume toggle. Active-low raw key.
- key_lap_n  in  1  lap-hold toggle. Active-low raw key.
- key_clr_n  in  1  clear to IDLE. Active-low raw key.
- preset_bcd  in  4*SEC_DIGITS  countdown start value in seconds, BCD, digit 0 = LSD.
- disp_bcd  out  4*SEC_DIGITS  displayed seconds.
- disp_tenth  out  4  displayed tenths digit.
- point  out  1  decimal point enable.
- alarm  out  1  alarm/LED drive.
- lap_active  out  1  display frozen by lap.
- state_o  out  3  current FSM state encoding.

Behaviour:
- Reset values: all outputs 0, FSM = IDLE, divider = 0, debouncers report released.
- Key path, per key:
  - 2-FF synchroniser, then stable counter.
  - One single-cycle press event when the level has been stable low for DEBOUNCE_CYC cycles.
  - Re-arms only after stable high for DEBOUNCE_CYC cycles.
  - Latency from stable low to event: DEBOUNCE_CYC + 2 cycles.
- Tick:
  - tick pulse every CLK_HZ/10 cycles while en=1 and state ∈ {UP, DOWN}.
  - Divider clears to 0 on any start or resume, so the first tick comes a full period later.
- FSM states: IDLE=0, UP=1, DOWN=2, PAUSE=3, DONE=4.
- Event priority when several arrive in the same cycle: clr > up > down > pause > lap. Only the winner acts.
- Transitions:
  - clr (any state) → IDLE. Count = 0, lap cleared, alarm = 0.
  - up (any state except while alarm is active) → UP. Count = 0.0.
  - down (same condition as up) → DOWN. Count = preset.0.
    - Any preset digit >9 is clamped to 9 at load.
    - A preset of all zeros goes directly to DONE with alarm.
  - pause in UP or DOWN → PAUSE. The previous direction is remembered.
  - pause in PAUSE → back to the remembered direction.
  - pause is ignored in IDLE and DONE.
  - lap in UP, DOWN or PAUSE toggles lap_active. It is ignored elsewhere.
- Counting, on each tick:
  - BCD ±0.1 s with ripple carry/borrow across tenths and all SEC_DIGITS. Each digit stays within 0..9.
  - UP at all-9s.9: WRAP_UP=1 wraps to 0.0. WRAP_UP=0 holds the value and goes to DONE with no alarm.
  - DOWN reaching 0.0 (the tick that produces 0.0) → DONE, and alarm=1 the following cycle.
- Alarm:
  - Stays high for ALARM_TICKS ticks. The divider keeps running in DONE while alarm=1.
  - Then drops; the state remains DONE.
  - clr drops the alarm immediately.
- Display:
  - disp_* follows the live count, registered, one cycle after the count update.
  - While lap_active=1, disp_* holds the value captured at the lap event and the live count continues.
  - Lap off: the display resumes live on the next cycle.
- point:
  - Toggles every 5 ticks (1 Hz blink) in UP/DOWN.
  - Steady 1 in PAUSE/DONE.
  - 0 in IDLE.
- Asynchronous rst mid-operation returns everything to reset values immediately. Pending debounce counts are discarded.
- en=0 in UP/DOWN: count frozen, divider held. The state is unchanged.

Decomposition:
- Shared package timer_pkg holds:
  - state encodings (IDLE..DONE).
  - TICK_HZ=10.
  - BCD digit max constant 4'd9.
  - a helper function for single-digit BCD inc/dec with carry.
- One sub-module: key_debounce (sync + stable counter + press pulse), instantiated 5×.
- BCD counter and FSM stay in the top.

Test Plan:
All scenarios use CLK_HZ=100 (tick every 10 cycles), DEBOUNCE_CYC=4 and SEC_DIGITS=2 unless stated.
1. Reset, then press up for 8 cycles, then wait 25 ticks → disp=02.5, point toggled 5 times, state_o=1.
2. preset=15, press down, then 150 ticks → disp=00.0, state_o=4, alarm high exactly ALARM_TICKS ticks, then 0.
3. UP at 12.3, press pause, wait 50 ticks → disp stays 12.3, point=1. Press pause again → counting resumes from 12.3 and first tick arrives 10 cycles after the event.
4. UP at 03.0, lap, 20 ticks → disp=03.0, lap_active=1. Lap again → disp=05.0.
5. Keys clr and up pressed in the same cycle → IDLE, disp=00.0. A 2-cycle glitch on key_up_n produces no event.
6. WRAP_UP=0, count 99.8, 2 ticks → disp=99.9, DONE, alarm=0. WRAP_UP=1 → 00.0 and still UP. preset=0xA5 loads as 95.

Source files
------------

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared state encodings, tick rate, BCD constants and the
//                single-digit BCD step helper for the timer core.
//  Revision    : 1.0  initial release
// ============================================================================
package timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_UP    = 3'd1,
    ST_DOWN  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int         TICK_HZ = 10;
  localparam logic [3:0] BCD_MAX = 4'd9;

  // One BCD digit step: returns {carry/borrow out, new digit}; no-op when cin=0.
  function automatic logic [4:0] bcd_step(input logic [3:0] d,
                                          input logic       down,
                                          input logic       cin);
    logic [4:0] r;
    r = {1'b0, d};
    if (cin) begin
      if (down) r = (d == 4'd0)    ? {1'b1, BCD_MAX} : {1'b0, d - 4'd1};
      else      r = (d >= BCD_MAX) ? {1'b1, 4'd0}    : {1'b0, d + 4'd1};
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/timer_core_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : timer_core_param_if
//  Description : Key, preset and BCD display bundle of the timer core.
//                master = board/bench side, slave = timer core side.
//  Revision    : 1.0  initial release
// ============================================================================
interface timer_core_param_if #(
  parameter int SEC_DIGITS = 2
) ();
  logic                    en;
  logic                    key_up_n;
  logic                    key_down_n;
  logic                    key_pause_n;
  logic                    key_lap_n;
  logic                    key_clr_n;
  logic [4*SEC_DIGITS-1:0] preset_bcd;
  logic [4*SEC_DIGITS-1:0] disp_bcd;
  logic [3:0]              disp_tenth;
  logic                    point;
  logic                    alarm;
  logic                    lap_active;
  logic [2:0]              state_o;

  modport master (
    output en, key_up_n, key_down_n, key_pause_n, key_lap_n, key_clr_n, preset_bcd,
    input  disp_bcd, disp_tenth, point, alarm, lap_active, state_o
  );

  modport slave (
    input  en, key_up_n, key_down_n, key_pause_n, key_lap_n, key_clr_n, preset_bcd,
    output disp_bcd, disp_tenth, point, alarm, lap_active, state_o
  );
endinterface
`default_nettype wire

// File: rtl/timer_core_param_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Active-low key synchroniser and debouncer. Emits one
//                single-cycle press pulse once the key has been stable low
//                for DEBOUNCE_CYC cycles; re-arms after the same stable high.
//  Revision    : 1.0  initial release
// ============================================================================
module key_debounce #(
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);
  localparam int               CNT_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;   // accepted (debounced) key level, 1 = released
  logic [CNT_W-1:0] r_cnt;

  // Synchronise, count cycles of disagreement with the accepted level, accept on expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
      press   <= 1'b0;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      press   <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        press   <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/timer_core_param.sv
`default_nettype none
// ============================================================================
//  Module      : timer_core_param
//  Description : Parametrised BCD stopwatch / countdown core with key
//                debounce, lap-hold display, wrap/saturate and timed alarm.
//  Revision    : 1.0  initial release
// ============================================================================
module timer_core_param
  import timer_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int SEC_DIGITS   = 2,
  parameter int DEBOUNCE_CYC = 500_000,
  parameter int ALARM_TICKS  = 30,
  parameter bit WRAP_UP      = 1'b0
) (
  input logic               clk_50M,
  input logic               rst,
  timer_core_param_if.slave bus
);
  localparam int               DIV_CYC  = CLK_HZ / TICK_HZ;
  localparam int               DIV_W    = (DIV_CYC > 1) ? $clog2(DIV_CYC) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_CYC - 1);
  localparam int               ALM_W    = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
  localparam logic [ALM_W-1:0] ALM_LAST = ALM_W'(ALARM_TICKS - 1);

  localparam int K_UP = 0, K_DOWN = 1, K_PAUSE = 2, K_LAP = 3, K_CLR = 4;

  // ---------------------------------------------------------------- keys
  logic [4:0] w_keys_n;
  logic [4:0] w_press;

  assign w_keys_n = {bus.key_clr_n, bus.key_lap_n, bus.key_pause_n,
                     bus.key_down_n, bus.key_up_n};

  for (genvar k = 0; k < 5; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
      .clk   (clk_50M),
      .rst   (rst),
      .key_n (w_keys_n[k]),
      .press (w_press[k])
    );
  end

  // Key events are dropped while disabled; the debouncers themselves keep running.
  logic w_ev_up, w_ev_down, w_ev_pause, w_ev_lap, w_ev_clr;
  assign w_ev_up    = bus.en & w_press[K_UP];
  assign w_ev_down  = bus.en & w_press[K_DOWN];
  assign w_ev_pause = bus.en & w_press[K_PAUSE];
  assign w_ev_lap   = bus.en & w_press[K_LAP];
  assign w_ev_clr   = bus.en & w_press[K_CLR];

  // ---------------------------------------------------------------- state
  state_t                       r_state;
  state_t                       r_dir;        // direction to resume into from PAUSE
  logic [3:0]                   r_tenth;
  logic [SEC_DIGITS-1:0][3:0]   r_sec;
  logic [3:0]                   r_hold_tenth;
  logic [SEC_DIGITS-1:0][3:0]   r_hold_sec;
  logic [DIV_W-1:0]             r_div;
  logic                         r_alarm;
  logic                         r_alarm_req;  // raise alarm on the cycle after reaching 0.0
  logic [ALM_W-1:0]             r_alarm_cnt;
  logic                         r_lap;
  logic                         r_blink;
  logic [2:0]                   r_blink_cnt;

  logic [3:0]                   r_disp_tenth;
  logic [SEC_DIGITS-1:0][3:0]   r_disp_sec;
  logic                         r_point;

  // ---------------------------------------------------------------- preset clamp
  logic [SEC_DIGITS-1:0][3:0]   w_preset;
  logic                         w_preset_zero;

  for (genvar i = 0; i < SEC_DIGITS; i++) begin : g_clamp
    assign w_preset[i] = (bus.preset_bcd[4*i +: 4] > BCD_MAX) ? BCD_MAX
                                                              : bus.preset_bcd[4*i +: 4];
  end
  assign w_preset_zero = (w_preset == '0);

  // ---------------------------------------------------------------- divider
  logic w_counting, w_div_run, w_tick, w_down;
  assign w_counting = (r_state == ST_UP) || (r_state == ST_DOWN);
  assign w_down     = (r_state == ST_DOWN);
  assign w_div_run  = bus.en && (w_counting || ((r_state == ST_DONE) && r_alarm));
  assign w_tick     = w_div_run && (r_div == DIV_LAST);

  // ---------------------------------------------------------------- next count
  logic [4:0]                 w_step;
  logic                       w_carry;
  logic [3:0]                 w_next_tenth;
  logic [SEC_DIGITS-1:0][3:0] w_next_sec;
  logic                       w_all_nine;
  logic                       w_next_zero;

  // Ripple the +/-0.1 s step from tenths through every seconds digit.
  always_comb begin
    w_step       = bcd_step(r_tenth, w_down, 1'b1);
    w_next_tenth = w_step[3:0];
    w_carry      = w_step[4];
    w_next_sec   = r_sec;
    w_all_nine   = (r_tenth == BCD_MAX);
    for (int i = 0; i < SEC_DIGITS; i++) begin
      w_step        = bcd_step(r_sec[i], w_down, w_carry);
      w_next_sec[i] = w_step[3:0];
      w_carry       = w_step[4];
      w_all_nine    = w_all_nine && (r_sec[i] == BCD_MAX);
    end
    w_next_zero = (w_next_tenth == 4'd0) && (w_next_sec == '0);
  end

  // Control FSM, divider, BCD count, lap capture, blink phase and alarm timing.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_dir        <= ST_UP;
      r_tenth      <= '0;
      r_sec        <= '0;
      r_hold_tenth <= '0;
      r_hold_sec   <= '0;
      r_div        <= '0;
      r_alarm      <= 1'b0;
      r_alarm_req  <= 1'b0;
      r_alarm_cnt  <= '0;
      r_lap        <= 1'b0;
      r_blink      <= 1'b0;
      r_blink_cnt  <= '0;
    end else begin
      r_alarm_req <= 1'b0;
      if (w_ev_clr) begin
        r_state     <= ST_IDLE;
        r_tenth     <= '0;
        r_sec       <= '0;
        r_div       <= '0;
        r_lap       <= 1'b0;
        r_alarm     <= 1'b0;
        r_alarm_cnt <= '0;
        r_blink     <= 1'b0;
        r_blink_cnt <= '0;
      end else if (w_ev_up && !r_alarm) begin
        r_state     <= ST_UP;
        r_tenth     <= '0;
        r_sec       <= '0;
        r_div       <= '0;
        r_lap       <= 1'b0;
        r_blink     <= 1'b0;
        r_blink_cnt <= '0;
      end else if (w_ev_down && !r_alarm) begin
        r_tenth     <= '0;
        r_sec       <= w_preset;
        r_div       <= '0;
        r_lap       <= 1'b0;
        r_blink     <= 1'b0;
        r_blink_cnt <= '0;
        if (w_preset_zero) begin
          r_state     <= ST_DONE;
          r_alarm_req <= 1'b1;
        end else begin
          r_state     <= ST_DOWN;
        end
      end else if (w_ev_pause && w_counting) begin
        r_state <= ST_PAUSE;
        r_dir   <= r_state;
      end else if (w_ev_pause && (r_state == ST_PAUSE)) begin
        r_state <= r_dir;
        r_div   <= '0;
      end else begin
        if (w_ev_lap && (w_counting || (r_state == ST_PAUSE))) begin
          r_lap <= ~r_lap;
          if (!r_lap) begin
            r_hold_tenth <= r_tenth;
            r_hold_sec   <= r_sec;
          end
        end

        if (w_div_run) begin
          r_div <= w_tick ? '0 : r_div + 1'b1;
        end

        if (w_tick && w_counting) begin
          if (r_blink_cnt == 3'd4) begin
            r_blink_cnt <= '0;
            r_blink     <= ~r_blink;
          end else begin
            r_blink_cnt <= r_blink_cnt + 3'd1;
          end
          if ((r_state == ST_UP) && w_all_nine && !WRAP_UP) begin
            r_state <= ST_DONE;
          end else begin
            r_tenth <= w_next_tenth;
            r_sec   <= w_next_sec;
            if (w_down && w_next_zero) begin
              r_state     <= ST_DONE;
              r_alarm_req <= 1'b1;
            end
          end
        end

        if (w_tick && (r_state == ST_DONE) && r_alarm) begin
          if (r_alarm_cnt == ALM_LAST) begin
            r_alarm <= 1'b0;
          end else begin
            r_alarm_cnt <= r_alarm_cnt + 1'b1;
          end
        end

        if (r_alarm_req) begin
          r_alarm     <= 1'b1;
          r_alarm_cnt <= '0;
        end
      end
    end
  end

  // Registered display: live count, or the lap snapshot while lap is held.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      r_disp_tenth <= '0;
      r_disp_sec   <= '0;
      r_point      <= 1'b0;
    end else begin
      r_disp_tenth <= r_lap ? r_hold_tenth : r_tenth;
      r_disp_sec   <= r_lap ? r_hold_sec   : r_sec;
      case (r_state)
        ST_UP, ST_DOWN:    r_point <= r_blink;
        ST_PAUSE, ST_DONE: r_point <= 1'b1;
        default:           r_point <= 1'b0;
      endcase
    end
  end

  assign bus.disp_bcd   = r_disp_sec;
  assign bus.disp_tenth = r_disp_tenth;
  assign bus.point      = r_point;
  assign bus.alarm      = r_alarm;
  assign bus.lap_active = r_lap;
  assign bus.state_o    = r_state;

endmodule
`default_nettype wire
